// File: rtl/tcam_match_encoder.sv
// tcam_match_encoder: registered priority encoder for a TCAM match-line vector.
// A match vector is captured under a valid/ready handshake. The block reports the
// highest-index matching entry together with hit and last flags. In multi mode it
// walks every matching entry, highest first, producing one response per handshake.
// Optional feature macro: TCAM_MATCH_COUNT_EN adds out_match_count, the popcount of
// the accepted vector, which is held for every response of that request.
module tcam_match_encoder #(
  parameter  int unsigned MATCH_WIDTH = 64,
  localparam int unsigned ADDR_WIDTH  = $clog2(MATCH_WIDTH)
) (
  input  logic                   in_clk,
  input  logic                   in_rst_n,
  input  logic                   in_req_valid,
  output logic                   out_req_ready,
  input  logic [MATCH_WIDTH-1:0] in_match,
  input  logic                   in_multi,
  output logic                   out_rsp_valid,
  input  logic                   in_rsp_ready,
  output logic                   out_hit,
  output logic [ADDR_WIDTH-1:0]  out_addr,
  output logic                   out_last
`ifdef TCAM_MATCH_COUNT_EN
  ,
  output logic [ADDR_WIDTH:0]    out_match_count
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [MATCH_WIDTH-1:0] pend_q, pend_d;
  logic                   multi_q, multi_d;
  logic                   req_ready_d;
  logic                   rsp_valid_d;
  logic                   hit_d;
  logic [ADDR_WIDTH-1:0]  addr_d;
  logic                   last_d;

`ifdef TCAM_MATCH_COUNT_EN
  localparam int unsigned CNT_WIDTH = ADDR_WIDTH + 1;
  logic [CNT_WIDTH-1:0]   count_d;

  // Number of set bits in a match vector.
  function automatic logic [CNT_WIDTH-1:0] popcount(input logic [MATCH_WIDTH-1:0] v);
    logic [CNT_WIDTH-1:0] c;
    c = '0;
    for (int unsigned i = 0; i < MATCH_WIDTH; i++) begin
      c = c + CNT_WIDTH'(v[i]);
    end
    return c;
  endfunction
`endif

  // Highest set index; an empty vector encodes to 0 (hit distinguishes the cases).
  function automatic logic [ADDR_WIDTH-1:0] top_index(input logic [MATCH_WIDTH-1:0] v);
    logic [ADDR_WIDTH-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < MATCH_WIDTH; i++) begin
      if (v[i]) begin
        idx = ADDR_WIDTH'(i);
      end
    end
    return idx;
  endfunction

  // True when exactly one bit of the vector is set.
  function automatic logic is_single(input logic [MATCH_WIDTH-1:0] v);
    return (v != '0) && ((v & (v - MATCH_WIDTH'(1))) == '0);
  endfunction

  // Drop one entry (the one just reported) from the pending vector.
  function automatic logic [MATCH_WIDTH-1:0] clear_entry(input logic [MATCH_WIDTH-1:0] v,
                                                         input logic [ADDR_WIDTH-1:0]  idx);
    logic [MATCH_WIDTH-1:0] r;
    r = v;
    for (int unsigned i = 0; i < MATCH_WIDTH; i++) begin
      if (ADDR_WIDTH'(i) == idx) begin
        r[i] = 1'b0;
      end
    end
    return r;
  endfunction

  // Next-state and next-output computation; every response field is re-encoded
  // from the next pending vector so outputs only ever come from flops.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    multi_d = multi_q;
    hit_d   = out_hit;
    addr_d  = out_addr;
    last_d  = out_last;
`ifdef TCAM_MATCH_COUNT_EN
    count_d = out_match_count;
`endif

    unique case (state_q)
      IDLE: begin
        if (in_req_valid) begin
          state_d = RESP;
          pend_d  = in_match;
          multi_d = in_multi;
          hit_d   = |in_match;
          addr_d  = top_index(in_match);
          last_d  = !in_multi || (in_match == '0) || is_single(in_match);
`ifdef TCAM_MATCH_COUNT_EN
          count_d = popcount(in_match);
`endif
        end
      end
      RESP: begin
        if (in_rsp_ready) begin
          if (out_last) begin
            state_d = IDLE;
            pend_d  = '0;
            multi_d = 1'b0;
`ifdef TCAM_MATCH_COUNT_EN
            count_d = '0;
`endif
          end else if (multi_q) begin
            pend_d = clear_entry(pend_q, out_addr);
            hit_d  = 1'b1;
            addr_d = top_index(pend_d);
            last_d = is_single(pend_d);
          end
        end
      end
      default: begin
        state_d = IDLE;
        pend_d  = '0;
        multi_d = 1'b0;
      end
    endcase

    req_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
  end

  // State, pending vector and all registered outputs.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_q       <= IDLE;
      pend_q        <= '0;
      multi_q       <= 1'b0;
      out_req_ready <= 1'b1;
      out_rsp_valid <= 1'b0;
      out_hit       <= 1'b0;
      out_addr      <= '0;
      out_last      <= 1'b0;
`ifdef TCAM_MATCH_COUNT_EN
      out_match_count <= '0;
`endif
    end else begin
      state_q       <= state_d;
      pend_q        <= pend_d;
      multi_q       <= multi_d;
      out_req_ready <= req_ready_d;
      out_rsp_valid <= rsp_valid_d;
      out_hit       <= hit_d;
      out_addr      <= addr_d;
      out_last      <= last_d;
`ifdef TCAM_MATCH_COUNT_EN
      out_match_count <= count_d;
`endif
    end
  end

endmodule

// File: tb/tb_tcam_match_encoder.sv
// Bench for tcam_match_encoder: a 64-entry and a 37-entry instance share one
// request stream; expected responses are queued per instance and a negedge
// monitor compares every presented response against the queue head.
module tb_tcam_match_encoder;

  localparam int unsigned WA = 64;
  localparam int unsigned WB = 37;

  typedef struct {
    logic hit;
    int   addr;
    logic last;
    int   cnt;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic [63:0]   match;
  logic          multi;
  logic          rsp_ready;

  logic          a_req_ready, a_rsp_valid, a_hit, a_last;
  logic [5:0]    a_addr;
  logic          b_req_ready, b_rsp_valid, b_hit, b_last;
  logic [5:0]    b_addr;
`ifdef TCAM_MATCH_COUNT_EN
  logic [6:0]    a_cnt;
  logic [6:0]    b_cnt;
`endif

  exp_t qa[$];
  exp_t qb[$];
  int   checks   = 0;
  int   failures = 0;
  int   rdy_mode = 1; // 0 random, 1 always ready, 2 stalled

  tcam_match_encoder #(.MATCH_WIDTH(WA)) dut_a (
    .in_clk        (clk),
    .in_rst_n      (rst_n),
    .in_req_valid  (req_valid),
    .out_req_ready (a_req_ready),
    .in_match      (match),
    .in_multi      (multi),
    .out_rsp_valid (a_rsp_valid),
    .in_rsp_ready  (rsp_ready),
    .out_hit       (a_hit),
    .out_addr      (a_addr),
    .out_last      (a_last)
`ifdef TCAM_MATCH_COUNT_EN
    ,
    .out_match_count (a_cnt)
`endif
  );

  tcam_match_encoder #(.MATCH_WIDTH(WB)) dut_b (
    .in_clk        (clk),
    .in_rst_n      (rst_n),
    .in_req_valid  (req_valid),
    .out_req_ready (b_req_ready),
    .in_match      (match[WB-1:0]),
    .in_multi      (multi),
    .out_rsp_valid (b_rsp_valid),
    .in_rsp_ready  (rsp_ready),
    .out_hit       (b_hit),
    .out_addr      (b_addr),
    .out_last      (b_last)
`ifdef TCAM_MATCH_COUNT_EN
    ,
    .out_match_count (b_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Response-side ready pattern, updated just after each rising edge.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       rsp_ready = ($urandom_range(0, 3) != 0);
      1:       rsp_ready = 1'b1;
      default: rsp_ready = 1'b0;
    endcase
  end

  // Reference model: list of responses for a vector seen by a w-entry encoder.
  task automatic push_exp(input int d, input logic [63:0] v, input int w, input logic m);
    int   idx[$];
    exp_t e;
    int   pc;
    for (int i = w - 1; i >= 0; i--) if (v[i]) idx.push_back(i);
    pc = idx.size();
    if (pc == 0) begin
      e = '{hit: 1'b0, addr: 0, last: 1'b1, cnt: 0};
      if (d == 0) qa.push_back(e); else qb.push_back(e);
    end else if (!m) begin
      e = '{hit: 1'b1, addr: idx[0], last: 1'b1, cnt: pc};
      if (d == 0) qa.push_back(e); else qb.push_back(e);
    end else begin
      for (int k = 0; k < pc; k++) begin
        e = '{hit: 1'b1, addr: idx[k], last: (k == pc - 1), cnt: pc};
        if (d == 0) qa.push_back(e); else qb.push_back(e);
      end
    end
  endtask

  task automatic check_rsp(input int d, input logic hit, input int addr, input logic last,
                           input int cnt, input logic rdy);
    exp_t e;
    logic bad;
    checks++;
    if ((d == 0 && qa.size() == 0) || (d == 1 && qb.size() == 0)) begin
      failures++;
      $display("FAIL rsp dut%0d unexpected response: got hit=%0d addr=%0d last=%0d, expected none",
               d, hit, addr, last);
    end else begin
      e = (d == 0) ? qa[0] : qb[0];
      bad = (hit !== e.hit) || (addr != e.addr) || (last !== e.last);
`ifdef TCAM_MATCH_COUNT_EN
      bad = bad || (cnt != e.cnt);
`endif
      if (bad) begin
        failures++;
        $display("FAIL rsp dut%0d: got hit=%0d addr=%0d last=%0d cnt=%0d, expected hit=%0d addr=%0d last=%0d cnt=%0d",
                 d, hit, addr, last, cnt, e.hit, e.addr, e.last, e.cnt);
      end
      if (rdy) begin
        if (d == 0) void'(qa.pop_front()); else void'(qb.pop_front());
      end
    end
  endtask

  // Monitor: compare every presented response; pop on handshake.
  always @(negedge clk) begin
    int ca, cb;
    ca = 0;
    cb = 0;
`ifdef TCAM_MATCH_COUNT_EN
    ca = int'(a_cnt);
    cb = int'(b_cnt);
`endif
    if (rst_n) begin
      if (a_rsp_valid) check_rsp(0, a_hit, int'(a_addr), a_last, ca, rsp_ready);
      if (b_rsp_valid) check_rsp(1, b_hit, int'(b_addr), b_last, cb, rsp_ready);
    end
  end

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  // Issue one request to both instances; afterwards scramble the request inputs.
  task automatic issue(input logic [63:0] v, input logic m);
    check("req_ready before issue", int'({a_req_ready, b_req_ready}), 3);
    req_valid = 1'b1;
    match     = v;
    multi     = m;
    push_exp(0, v, WA, m);
    push_exp(1, v, WB, m);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    match     = {$urandom, $urandom};
    multi     = 1'($urandom);
  endtask

  // Wait for both instances to return to idle; na = edges until dut_a idle.
  task automatic wait_idle(output int na);
    int n;
    n  = 0;
    na = -1;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (a_req_ready && na < 0) na = n;
    end while (!(a_req_ready && b_req_ready) && n < 500);
    if (!(a_req_ready && b_req_ready)) begin
      checks++;
      failures++;
      $display("FAIL idle timeout: got req_ready=%0d%0d, expected 11", a_req_ready, b_req_ready);
    end
  endtask

  task automatic set_rdy(input int mode);
    rdy_mode  = mode;
    rsp_ready = (mode == 1);
  endtask

  initial begin
    int            na;
    logic [63:0]   v;
    int            kind;

    rst_n     = 1'b1;
    req_valid = 1'b0;
    match     = '0;
    multi     = 1'b0;
    rsp_ready = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("reset req_ready", int'(a_req_ready), 1);
    check("reset rsp_valid", int'(a_rsp_valid), 0);
    check("reset hit/addr/last", int'({a_hit, a_addr, a_last}), 0);
    check("reset dut_b rsp_valid/req_ready", int'({b_rsp_valid, b_req_ready}), 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single mode, both extremes set: dut_a reports 63, dut_b only sees bit 0.
    set_rdy(1);
    issue(64'h8000_0000_0000_0001, 1'b0);
    check("latency rsp_valid after accept", int'(a_rsp_valid), 1);
    wait_idle(na);

    // Empty vector in both modes.
    issue(64'h0, 1'b0);
    wait_idle(na);
    issue(64'h0, 1'b1);
    wait_idle(na);
    check("empty multi single response idle edges", na, 1);

    // Multi 0x111 back-to-back: three responses then ready the next cycle.
    issue(64'h0000_0000_0000_0111, 1'b1);
    wait_idle(na);
    check("multi 0x111 edges to req_ready", na, 3);

    // Stall: bits {40,2} held for 3 cycles before the handshake.
    set_rdy(2);
    issue((64'h1 << 40) | 64'h4, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("stall addr held", int'(a_addr), 40);
    set_rdy(1);
    wait_idle(na);

    // Bits {36,5,0}: dut_b reports 36 first, count 3 on every response.
    issue((64'h1 << 36) | 64'h21, 1'b1);
    wait_idle(na);
    check("multi {36,5,0} edges to req_ready", na, 3);

    // Reset during the second response of a 4-match request.
    issue((64'h1 << 60) | (64'h1 << 33) | (64'h1 << 20) | 64'h2, 1'b1);
    @(posedge clk);
    #3;
    check("second response addr before reset", int'(a_addr), 33);
    rst_n = 1'b0;
    #1;
    check("rsp_valid cleared by async reset", int'({a_rsp_valid, b_rsp_valid}), 0);
    check("outputs cleared by async reset", int'({a_hit, a_addr, a_last, a_req_ready}), 1);
    qa.delete();
    qb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("req_ready after reset release", int'({a_req_ready, b_req_ready}), 3);
    repeat (4) @(posedge clk);
    #1;
    check("no stale response after reset", int'({a_rsp_valid, b_rsp_valid}), 0);

    // Randomized requests with random downstream back-pressure.
    set_rdy(0);
    for (int r = 0; r < 300; r++) begin
      kind = $urandom_range(0, 3);
      case (kind)
        0: v = '0;
        1: v = 64'h1 << $urandom_range(0, 63);
        2: begin
          v = '0;
          for (int j = 0; j < int'($urandom_range(1, 5)); j++) v[$urandom_range(0, 63)] = 1'b1;
        end
        default: v = {$urandom, $urandom};
      endcase
      issue(v, 1'($urandom));
      wait_idle(na);
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk);
        #1;
      end
    end

    set_rdy(1);
    repeat (3) @(posedge clk);
    #1;
    check("scoreboard drained", qa.size() + qb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time limit so the bench always terminates.
  initial begin
    #2000000;
    $display("FAIL global timeout: got no completion, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/tcam_match_encoder.md
Name: tcam_match_encoder

Overview:
- Parametrised, registered successor to the TCAM fixed 64-entry priority encoder.
- Sits between the TCAM match-line array and the lookup result interface.
- Captures a match vector under a valid/ready handshake and reports the highest-index matching entry, plus hit and last flags.
- Multi-match mode returns every matching entry, one per response handshake, highest index first.

Parameters:
- MATCH_WIDTH, 64, number of match lines (entries); legal range >= 2, power of two not required.
- ADDR_WIDTH, $clog2(MATCH_WIDTH), width of the reported entry index; derived, never overridden.

Ports:
- in_clk  input  1  clock; all state updates on the rising edge.
- in_rst_n  input  1  asynchronous active-low reset.
- in_req_valid  input  1  match vector and mode are valid this cycle.
- out_req_ready  output  1  block can accept a request.
- in_match  input  MATCH_WIDTH  match-line vector; bit i set means entry i matched.
- in_multi  input  1  0 = single (highest) result; 1 = iterate over all matches.
- out_rsp_valid  output  1  response fields are valid.
- in_rsp_ready  input  1  downstream accepts the response.
- out_hit  output  1  response refers to a real matching entry.
- out_addr  output  ADDR_WIDTH  entry index of the response.
- out_last  output  1  final response for the current request.

Behaviour:
- Clock/reset: one clock; reset is asynchronous, active-low on in_rst_n.
- Reset values:
  - state = IDLE, pending vector = 0.
  - out_rsp_valid = 0, out_hit = 0, out_addr = 0, out_last = 0, out_req_ready = 1.
- State machine: IDLE and RESP.
  - out_req_ready = (state == IDLE), registered.
  - out_rsp_valid = (state == RESP).
- IDLE, in_req_valid = 1 (accept):
  - Pending vector is loaded with in_match; multi flag is latched.
  - out_addr is loaded with the highest set index of in_match.
  - out_hit is loaded with |in_match.
  - out_last is loaded with: 1 if not multi; 1 if the vector is zero; otherwise 1 only if exactly one bit is set.
  - Transition to RESP. Latency is 1 cycle: the response is visible the cycle after acceptance.
- Empty vector: out_hit = 0, out_addr = 0, out_last = 1. Exactly one response is produced in both modes.
- RESP with in_rsp_ready = 0: all outputs and the pending vector hold (stall). Inputs on the request side are ignored.
- RESP with in_rsp_ready = 1 and out_last = 1: transition to IDLE and clear the pending vector. out_rsp_valid drops next cycle and out_req_ready rises next cycle. There is no same-cycle re-accept, so minimum request spacing is 2 cycles.
- RESP with in_rsp_ready = 1 and out_last = 0 (multi only):
  - Bit out_addr is cleared in the pending vector.
  - Next cycle, out_addr = highest set index of the cleared vector and out_hit = 1.
  - out_last = 1 iff the cleared vector has exactly one bit set.
  - Stay in RESP. Back-to-back handshakes yield one response per cycle.
- Priority rule: a higher index always wins. Bit 0 alone reports addr 0 with hit = 1, distinguished from no-match by out_hit.
- in_multi and in_match are sampled only at acceptance. Later changes have no effect on the active request.
- Reset asserted mid-RESP: outputs clear immediately (asynchronously). The in-flight request is discarded; no partial responses are produced after release.
- Encoding is a combinational search on the next-pending vector, registered into out_addr. No combinational path runs from in_rsp_ready to any output.

Optional Feature:
- Macro: TCAM_MATCH_COUNT_EN.
- Defined:
  - Adds output port out_match_count, width ADDR_WIDTH+1.
  - Holds the popcount of in_match, registered at acceptance and held constant for all responses of that request.
  - Resets to 0 and returns to 0 on the IDLE transition.
- Undefined: the port and the popcount logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then single mode with in_match = 64'h8000_0000_0000_0001 -> one cycle later out_rsp_valid = 1, out_hit = 1, out_addr = 63, out_last = 1.
- Single mode, in_match = 0 -> out_hit = 0, out_addr = 0, out_last = 1; multi mode with in_match = 0 gives the same single response.
- Multi mode, in_match = 64'h0000_0000_0000_0111, in_rsp_ready held 1:
  - Responses on consecutive cycles are addr 8/last 0, addr 4/last 0, addr 0/last 1.
  - out_req_ready returns to 1 on the following cycle.
- Multi mode, in_match = bits {40, 2}, in_rsp_ready = 0 for 3 cycles -> addr 40 held stable for 3 cycles; then addr 2 with last = 1 after the handshake.
- Assert in_rst_n = 0 during the second response of a 4-match request -> out_rsp_valid = 0 immediately; after release out_req_ready = 1 and no stale response appears.
- MATCH_WIDTH = 37, in_match bit 36 set, TCAM_MATCH_COUNT_EN defined with bits {36, 5, 0} set:
  - ADDR_WIDTH = 6, out_addr = 36.
  - out_match_count = 3 on all three multi-mode responses.
